frec_meter: RTL

- Frequency counter: the measuring end for slow square waves such as the output of the team's frequency divider.
- Counts rising edges of an asynchronous input over a fixed gate window of GATE_CYCLES clocks.
- Publishes the edge count once per window with a one-cycle valid strobe.
- Sits between external/divided signal sources and the display/LED logic on the board clock domain.

---
 rtl/frec_meter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/frec_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over a
// fixed window of GATE_CYCLES clocks and publishes the count once per window.
module frec_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEnable,
  input  logic             iSig,
  output logic [CNT_W-1:0] oCount,
  output logic             oValid,
  output logic             oOverflow,
  output logic             oBusy
);

  localparam int unsigned      GW       = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GateLast = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [0:0] {
    StIdle,
    StGate
  } state_e;

  state_e r_state;
  state_e w_state_d;

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_rise;

  logic [GW-1:0]    r_gate_cnt;
  logic [GW-1:0]    w_gate_cnt_d;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] w_edge_cnt_d;
  logic             r_sat;
  logic             w_sat_d;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_d;
  logic             r_ovf;
  logic             w_ovf_d;
  logic             r_valid;
  logic             w_valid_d;

  logic w_terminal;
  logic w_edge_full;

  // Synchronizer and edge detector run in every state so that a level already
  // present when a window opens is never mistaken for an edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= iSig;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
    end
  end

  assign w_terminal  = (r_state == StGate) && (r_gate_cnt == GateLast);
  assign w_edge_full = (r_edge_cnt == CntMax);

  always_comb begin
    w_state_d    = r_state;
    w_gate_cnt_d = r_gate_cnt;
    w_edge_cnt_d = r_edge_cnt;
    w_sat_d      = r_sat;
    w_count_d    = r_count;
    w_ovf_d      = r_ovf;
    w_valid_d    = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_gate_cnt_d = '0;
        w_edge_cnt_d = '0;
        w_sat_d      = 1'b0;
        if (iEnable) begin
          w_state_d = StGate;
        end
      end

      StGate: begin
        if (w_terminal) begin
          // The terminal cycle's own edge is folded into the published result.
          if (r_rise && w_edge_full) begin
            w_count_d = CntMax;
            w_ovf_d   = 1'b1;
          end else begin
            w_count_d = r_edge_cnt + CNT_W'(r_rise);
            w_ovf_d   = r_sat;
          end
          w_valid_d    = 1'b1;
          w_gate_cnt_d = '0;
          w_edge_cnt_d = '0;
          w_sat_d      = 1'b0;
          w_state_d    = iEnable ? StGate : StIdle;
        end else if (!iEnable) begin
          w_gate_cnt_d = '0;
          w_edge_cnt_d = '0;
          w_sat_d      = 1'b0;
          w_state_d    = StIdle;
        end else begin
          w_gate_cnt_d = r_gate_cnt + GW'(1);
          if (r_rise) begin
            if (w_edge_full) begin
              w_sat_d = 1'b1;
            end else begin
              w_edge_cnt_d = r_edge_cnt + CNT_W'(1);
            end
          end
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state    <= StIdle;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_gate_cnt <= w_gate_cnt_d;
      r_edge_cnt <= w_edge_cnt_d;
      r_sat      <= w_sat_d;
      r_count    <= w_count_d;
      r_ovf      <= w_ovf_d;
      r_valid    <= w_valid_d;
    end
  end

  assign oCount    = r_count;
  assign oOverflow = r_ovf;
  assign oValid    = r_valid;
  assign oBusy     = (r_state == StGate);

endmodule
